// File: rtl/letreiro_scan_ctrl.sv
// Row-scan, scroll and reload sequencer for the 5x7 LED marquee.
// Every output is a Moore decode of the registers below, gated by the run state.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | in reset or on the start edge; outputs held at 0
// ST_RUN  | scanning rows; mode may change only at frame boundaries
module letreiro_scan_ctrl #(
   parameter int ROWS       = 5,
   parameter int SCAN_DIV   = 1000,
   parameter int BLANK_CYC  = 4,
   parameter int SCROLL_DIV = 50
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ch0,
   input  logic            ch1,
   output logic [ROWS-1:0] row_sel,
   output logic [2:0]      row_idx,
   output logic            col_en,
   output logic            frame_start,
   output logic            shift_en,
   output logic            shift_dir,
   output logic            load_en,
   output logic [1:0]      mode
);

   localparam int CW = $clog2(SCAN_DIV + 1);
   localparam int FW = $clog2(SCROLL_DIV + 1);
   localparam logic [CW-1:0] CYC_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYC);
   localparam logic [2:0]    ROW_LAST  = 3'(ROWS - 1);
   localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_DIV - 1);

   localparam logic [1:0] MODE_SCROLL_L = 2'b01;
   localparam logic [1:0] MODE_SCROLL_R = 2'b10;
   localparam logic [1:0] MODE_RELOAD   = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [2:0]      row_q, row_d;
   logic [1:0]      mode_q, mode_d;
   logic            mode_new_q, mode_new_d;
   logic [FW-1:0]   frame_cnt_q, frame_cnt_d;

   logic run;
   logic start;
   logic cyc_wrap;
   logic frame_end;
   logic mode_load;
   logic mode_chg;
   logic scroll;
   logic fs;

   // The synchronizer is never reset so the switch value is already settled
   // when the start edge samples it.
   always_comb begin
      sync1_d = {ch1, ch0};
      sync2_d = sync1_q;
   end

   always_ff @(posedge CLK) begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
   end

   always_comb begin
      run       = (state_q == ST_RUN);
      start     = (state_q == ST_IDLE);
      cyc_wrap  = (cyc_q == CYC_LAST);
      frame_end = run && cyc_wrap && (row_q == ROW_LAST);
      mode_load = start || frame_end;
      mode_chg  = (sync2_q != mode_q);
      scroll    = (mode_q == MODE_SCROLL_L) || (mode_q == MODE_SCROLL_R);
      fs        = run && (row_q == 3'd0) && (cyc_q == '0);
   end

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      row_d       = row_q;
      mode_d      = mode_q;
      mode_new_d  = mode_new_q;
      frame_cnt_d = frame_cnt_q;

      if (start) begin
         state_d = ST_RUN;
      end

      if (run) begin
         if (cyc_wrap) begin
            cyc_d = '0;
            row_d = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
         end else begin
            cyc_d = cyc_q + CW'(1);
         end
      end

      // mode_new marks the first frame after a (re)load so RELOAD pulses once.
      if (mode_load) begin
         mode_d     = sync2_q;
         mode_new_d = start || mode_chg;
      end

      if (start || !scroll || (frame_end && mode_chg)) begin
         frame_cnt_d = '0;
      end else if (fs) begin
         frame_cnt_d = (frame_cnt_q == FRM_LAST) ? '0 : frame_cnt_q + FW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cyc_q       <= '0;
         row_q       <= 3'd0;
         mode_q      <= 2'b00;
         mode_new_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         row_q       <= row_d;
         mode_q      <= mode_d;
         mode_new_q  <= mode_new_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      frame_start = fs;
      col_en      = run && (cyc_q >= CYC_BLANK);
      row_sel     = col_en ? (ROWS'(1) << row_q) : '0;
      row_idx     = run ? row_q : 3'd0;
      mode        = mode_q;
      shift_dir   = run && (mode_q == MODE_SCROLL_R);
      shift_en    = fs && scroll && (frame_cnt_q == '0);
      load_en     = fs && (mode_q == MODE_RELOAD) && mode_new_q;
   end

endmodule
